result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector.sv | 174 +++++++++++++++++
 tb/tb_result_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// rtl/result_collector.sv - assembles hi/lo multiplier bytes into 16-bit results and queues them in a FIFO
// Optional per-entry zero/neg flags are built only when RESULT_FLAGS_EN is defined.
module result_collector #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [7:0]  byte_in,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        end_op,
  input  logic        out_ready,
  input  logic        err_clr,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        full,
  output logic        seq_err,
  output logic        ovf,
  output logic        out_zero,
  output logic        out_neg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_HI  = 2'd0;
  localparam logic [1:0] S_LO  = 2'd1;
  localparam logic [1:0] S_CMT = 2'd2;

  logic [1:0]    r_state;
  logic [7:0]    r_hi;
  logic [7:0]    r_lo;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_mem [DEPTH];
  logic          r_seq_err;
  logic          r_ovf;

  logic [1:0] w_next;
  logic       w_err;
  logic       w_discard;
  logic       w_ld_hi;
  logic       w_ld_lo;
  logic       w_push_req;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic [15:0] w_word;

  // Simultaneous hi/lo strobes outrank every state-specific rule.
  always_comb begin
    w_next     = r_state;
    w_err      = 1'b0;
    w_discard  = 1'b0;
    w_ld_hi    = 1'b0;
    w_ld_lo    = 1'b0;
    w_push_req = 1'b0;
    if (hi_we && lo_we) begin
      w_err     = 1'b1;
      w_discard = 1'b1;
      w_next    = S_HI;
    end else begin
      case (r_state)
        S_HI: begin
          if (lo_we || end_op) begin
            w_err     = 1'b1;
            w_discard = 1'b1;
          end else if (hi_we) begin
            w_ld_hi = 1'b1;
            w_next  = S_LO;
          end
        end
        S_LO: begin
          if (end_op) begin
            w_err     = 1'b1;
            w_discard = 1'b1;
            w_next    = S_HI;
          end else if (lo_we) begin
            w_ld_lo = 1'b1;
            w_next  = S_CMT;
          end else if (hi_we) begin
            w_ld_hi = 1'b1;
          end
        end
        S_CMT: begin
          if (hi_we || lo_we) w_err = 1'b1;
          if (end_op) begin
            w_push_req = 1'b1;
            w_next     = S_HI;
          end
        end
        default: w_next = S_HI;
      endcase
    end
  end

  assign w_word  = {r_hi, r_lo};
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_pop   = !w_empty && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_state   <= S_HI;
      r_hi      <= '0;
      r_lo      <= '0;
      r_seq_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_discard) begin
        r_hi <= '0;
        r_lo <= '0;
      end else begin
        if (w_ld_hi) r_hi <= byte_in;
        if (w_ld_lo) r_lo <= byte_in;
      end
      if (w_err)        r_seq_err <= 1'b1;
      else if (err_clr) r_seq_err <= 1'b0;
      if (w_drop)       r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_word;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign out_data  = w_empty ? 16'h0000 : r_mem[r_rptr];
  assign out_valid = !w_empty;
  assign full      = w_full;
  assign seq_err   = r_seq_err;
  assign ovf       = r_ovf;

`ifdef RESULT_FLAGS_EN
  logic [1:0] r_flg [DEPTH];

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int i = 0; i < DEPTH; i++) r_flg[i] <= '0;
    end else if (w_push) begin
      r_flg[r_wptr] <= {(w_word == 16'h0000), r_hi[7]};
    end
  end

  assign out_zero = !w_empty && r_flg[r_rptr][1];
  assign out_neg  = !w_empty && r_flg[r_rptr][0];
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - scoreboard bench for result_collector with DEPTH=2 and DEPTH=4 instances
module tb_result_collector;
  logic       clk = 1'b0;
  logic       rst_b;
  logic [7:0] byte_in;
  logic       hi_we, lo_we, end_op, err_clr;
  logic       sel, rdy2, rdy4, rnd4;

  logic [15:0] d2, d4;
  logic        v2, f2, se2, ov2, z2, n2;
  logic        v4, f4, se4, ov4, z4, n4;

  int n_cmp = 0;
  int n_err = 0;
  int npop4 = 0;
  logic [17:0] q2[$];
  logic [17:0] q4[$];

`ifdef RESULT_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  always #5 clk = ~clk;

  result_collector #(.DEPTH(2)) u2 (
    .clk(clk), .rst_b(rst_b), .byte_in(byte_in),
    .hi_we(hi_we & ~sel), .lo_we(lo_we & ~sel), .end_op(end_op & ~sel),
    .out_ready(rdy2), .err_clr(err_clr & ~sel),
    .out_data(d2), .out_valid(v2), .full(f2), .seq_err(se2), .ovf(ov2),
    .out_zero(z2), .out_neg(n2)
  );

  result_collector #(.DEPTH(4)) u4 (
    .clk(clk), .rst_b(rst_b), .byte_in(byte_in),
    .hi_we(hi_we & sel), .lo_we(lo_we & sel), .end_op(end_op & sel),
    .out_ready(rdy4), .err_clr(err_clr & sel),
    .out_data(d4), .out_valid(v4), .full(f4), .seq_err(se4), .ovf(ov4),
    .out_zero(z4), .out_neg(n4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ent(input logic [7:0] h, input logic [7:0] l);
    logic z, n;
    z = FL & ({h, l} == 16'h0000);
    n = FL & h[7];
    return {z, n, h, l};
  endfunction

  task automatic tick();
    logic [17:0] e;
    if (rnd4) rdy4 = (q4.size() >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
    if (rdy2 && v2) begin
      if (q2.size() == 0) begin
        n_cmp++; n_err++;
        $error("FAIL pop2_extra: observed %0h expected no entry", d2);
      end else begin
        e = q2.pop_front();
        chk("pop2", {z2, n2, d2}, e);
      end
    end
    if (rdy4 && v4) begin
      npop4++;
      if (q4.size() == 0) begin
        n_cmp++; n_err++;
        $error("FAIL pop4_extra: observed %0h expected no entry", d4);
      end else begin
        e = q4.pop_front();
        chk("pop4", {z4, n4, d4}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] l);
    byte_in = h; hi_we = 1'b1; tick(); hi_we = 1'b0;
    byte_in = l; lo_we = 1'b1; tick(); lo_we = 1'b0;
  endtask

  task automatic commit(input logic [7:0] h, input logic [7:0] l, input bit rec);
    if (rec) begin
      if (sel) q4.push_back(ent(h, l));
      else     q2.push_back(ent(h, l));
    end
    end_op = 1'b1; tick(); end_op = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_d2"}, d2, 16'h0);   chk({tag, "_v2"}, v2, 1'b0);
    chk({tag, "_f2"}, f2, 1'b0);    chk({tag, "_se2"}, se2, 1'b0);
    chk({tag, "_ov2"}, ov2, 1'b0);  chk({tag, "_z2"}, z2, 1'b0);
    chk({tag, "_n2"}, n2, 1'b0);
    chk({tag, "_u4"}, {d4, v4, f4, se4, ov4, z4, n4}, 22'h0);
  endtask

  initial begin
    rst_b = 1'b1; byte_in = '0; hi_we = 0; lo_we = 0; end_op = 0; err_clr = 0;
    sel = 0; rdy2 = 0; rdy4 = 0; rnd4 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_b = 1'b0;
    tick();

    // Basic result with one-cycle push latency, then pop
    rdy2 = 1'b1;
    load(8'hFF, 8'h80);
    commit(8'hFF, 8'h80, 1);
    chk("lat_valid", v2, 1'b1);
    chk("lat_data", d2, 16'hFF80);
    chk("lat_neg", n2, FL);
    chk("lat_zero", z2, 1'b0);
    tick();
    chk("after_pop_valid", v2, 1'b0);
    chk("empty_data", d2, 16'h0);

    // hi overwrite while waiting for lo
    byte_in = 8'h11; hi_we = 1'b1; tick();
    byte_in = 8'h22; tick(); hi_we = 1'b0;
    byte_in = 8'h33; lo_we = 1'b1; tick(); lo_we = 1'b0;
    commit(8'h22, 8'h33, 1);
    chk("overwrite_noerr", se2, 1'b0);
    tick();

    // Fill, overflow, then push+pop while full
    rdy2 = 1'b0;
    load(8'h00, 8'h01); commit(8'h00, 8'h01, 1);
    chk("one_notfull", f2, 1'b0);
    load(8'h00, 8'h02); commit(8'h00, 8'h02, 1);
    chk("two_full", f2, 1'b1);
    chk("two_noovf", ov2, 1'b0);
    load(8'h00, 8'h03); commit(8'h00, 8'h03, 0);
    chk("drop_ovf", ov2, 1'b1);
    chk("drop_full", f2, 1'b1);
    chk("drop_head_stable", d2, 16'h0001);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("ovf_clr", ov2, 1'b0);
    load(8'h12, 8'h34);
    chk("hold_head_stable", d2, 16'h0001);
    rdy2 = 1'b1;
    commit(8'h12, 8'h34, 1);
    chk("pushpop_noovf", ov2, 1'b0);
    chk("pushpop_full", f2, 1'b1);
    tick(); tick();
    chk("drain_empty", v2, 1'b0);
    chk("drain_q", q2.size(), 0);

    // Protocol violations
    lo_we = 1'b1; tick(); lo_we = 1'b0;
    chk("lo_in_hi_err", se2, 1'b1);
    chk("lo_in_hi_nopush", v2, 1'b0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr1", se2, 1'b0);
    byte_in = 8'hAA; hi_we = 1'b1; tick(); hi_we = 1'b0;
    end_op = 1'b1; tick(); end_op = 1'b0;
    chk("end_in_lo_err", se2, 1'b1);
    chk("end_in_lo_nopush", v2, 1'b0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr2", se2, 1'b0);
    hi_we = 1'b1; lo_we = 1'b1; tick(); hi_we = 1'b0; lo_we = 1'b0;
    chk("both_err", se2, 1'b1);
    err_clr = 1'b1; lo_we = 1'b1; tick(); err_clr = 1'b0; lo_we = 1'b0;
    chk("err_wins_clr", se2, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr3", se2, 1'b0);
    chk("viol_nopush", v2, 1'b0);
    load(8'h00, 8'h00); commit(8'h00, 8'h00, 1);
    chk("zero_valid", v2, 1'b1);
    chk("zero_flag", z2, FL);
    chk("zero_neg", n2, 1'b0);
    tick();
    chk("zero_popped", v2, 1'b0);

    // Reset mid-assembly with a full FIFO
    rdy2 = 1'b0;
    load(8'h01, 8'h02); commit(8'h01, 8'h02, 1);
    load(8'h03, 8'h04); commit(8'h03, 8'h04, 1);
    chk("pre_rst_full", f2, 1'b1);
    byte_in = 8'h55; hi_we = 1'b1; tick(); hi_we = 1'b0;
    rst_b = 1'b1;
    #1;
    chk_idle("midrst");
    q2.delete();
    tick();
    rst_b = 1'b0;
    tick();
    chk("post_rst_empty", v2, 1'b0);
    rdy2 = 1'b1;
    load(8'hAB, 8'hCD); commit(8'hAB, 8'hCD, 1);
    chk("post_rst_data", d2, 16'hABCD);
    tick();
    chk("post_rst_q", q2.size(), 0);

    // DEPTH=4 stream with random consumer back-pressure
    rdy2 = 1'b0;
    sel = 1'b1; rnd4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] h, l;
      h = 8'($urandom); l = 8'($urandom);
      load(h, l);
      commit(h, l, 1);
    end
    rnd4 = 1'b0; rdy4 = 1'b1;
    for (int k = 0; k < 20 && q4.size() != 0; k++) tick();
    chk("d4_drained", q4.size(), 0);
    chk("d4_pops", npop4, 6);
    chk("d4_noovf", ov4, 1'b0);
    chk("d4_empty", v4, 1'b0);
    chk("d4_noerr", se4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
